// File: rtl/tp_pkg.sv
// Shared constants and element helper for the ping-pong block transpose memory.
package tp_pkg;
  localparam int TP_BW = 10;
  localparam int TP_N  = 8;
  localparam int IDX_W = $clog2(TP_N);

  // Element 0 sits in the MSB slice of a word.
  function automatic logic [TP_BW-1:0] tp_elem(input logic [TP_N*TP_BW-1:0] word, input int j);
    return word[(TP_N-1-j)*TP_BW +: TP_BW];
  endfunction
endpackage

// File: rtl/tp_bank.sv
// One N x N element register array; reads out either a column (transpose) or a row.
module tp_bank import tp_pkg::*; #(
  parameter int BW = TP_BW,
  parameter int N  = TP_N,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wrow,
  input  logic [N*BW-1:0] wdata,
  input  logic [IW-1:0] ridx,
  input  logic          mode,
  output logic [N*BW-1:0] rdata
);
  logic [N*BW-1:0] mem [N];

  // Contents are deliberately not reset; full flags in the top gate visibility.
  always_ff @(posedge clk) begin
    if (we) mem[wrow] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if (mode) begin
      for (int k = 0; k < N; k++)
        rdata[(N-1-k)*BW +: BW] = mem[k][(N-1-int'(ridx))*BW +: BW];
    end else begin
      rdata = mem[ridx];
    end
  end
endmodule

// File: rtl/tp_mem_pingpong.sv
// Two-bank ping-pong transpose buffer: one bank fills row-wise while the other drains.
module tp_mem_pingpong import tp_pkg::*; #(
  parameter int BW = TP_BW,
  parameter int N  = TP_N
) (
  input  logic          i_clk,
  input  logic          i_Reset,
  input  logic [N*BW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_mode,
  output logic [N*BW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_mode
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);

  logic [1:0]    full;
  logic [1:0]    mode_q;
  logic          wbank, rbank;
  logic [IW-1:0] wrow, ridx;
  logic          wr_acc, rd_acc;
  logic [N*BW-1:0] rdata [2];

  assign wr_acc = i_valid && !full[wbank];
  assign rd_acc = full[rbank] && i_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tp_bank #(.BW(BW), .N(N)) u_bank (
      .clk   (i_clk),
      .we    (wr_acc && (wbank == 1'(b))),
      .wrow  (wrow),
      .wdata (i_data),
      .ridx  (ridx),
      .mode  (mode_q[b]),
      .rdata (rdata[b])
    );
  end

  // All outputs derive from flops only; no combinational path from i_valid/i_ready.
  assign o_ready = !full[wbank];
  assign o_valid = full[rbank];
  assign o_data  = full[rbank] ? rdata[rbank] : '0;
  assign o_mode  = full[rbank] & mode_q[rbank];

  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      full   <= '0;
      mode_q <= '0;
      wbank  <= 1'b0;
      rbank  <= 1'b0;
      wrow   <= '0;
      ridx   <= '0;
    end else begin
      if (wr_acc) begin
        if (wrow == '0) mode_q[wbank] <= i_mode;
        if (wrow == LAST) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
          wrow        <= '0;
        end else begin
          wrow <= wrow + 1'b1;
        end
      end
      // A bank being drained is never the one being written, so bit updates never collide.
      if (rd_acc) begin
        if (ridx == LAST) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
          ridx        <= '0;
        end else begin
          ridx <= ridx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tp_mem_pingpong.sv
// Self-checking bench for tp_mem_pingpong: directed vector table, corner sequences, random N=4 run.
module tb_tp_mem_pingpong;
  localparam int BW = 10, N = 8, W = 80;
  localparam int BW2 = 3, N2 = 4, W2 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  i_data, o_data;
  logic          i_valid, o_ready, i_mode, o_valid, i_ready, o_mode;
  logic [W2-1:0] c_data, c_odata;
  logic          c_valid, c_oready, c_mode, c_ovalid, c_ready, c_omode;

  tp_mem_pingpong #(.BW(BW), .N(N)) dut (
    .i_clk(clk), .i_Reset(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_mode(o_mode)
  );

  tp_mem_pingpong #(.BW(BW2), .N(N2)) dut4 (
    .i_clk(clk), .i_Reset(rst_n), .i_data(c_data), .i_valid(c_valid), .o_ready(c_oready),
    .i_mode(c_mode), .o_data(c_odata), .o_valid(c_ovalid), .i_ready(c_ready), .o_mode(c_omode)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Row r of block b: element j = 64b + 8r + j.
  function automatic logic [W-1:0] row_w(input int b, input int r);
    logic [W-1:0] w;
    for (int j = 0; j < N; j++) w[(N-1-j)*BW +: BW] = BW'(64*b + 8*r + j);
    return w;
  endfunction

  // Column c of block b: element k = row k element c.
  function automatic logic [W-1:0] col_w(input int b, input int c);
    logic [W-1:0] w;
    for (int k = 0; k < N; k++) w[(N-1-k)*BW +: BW] = BW'(64*b + 8*k + c);
    return w;
  endfunction

  function automatic logic [W2-1:0] tr4(input logic [3:0][W2-1:0] rows, input int c);
    logic [W2-1:0] w;
    for (int k = 0; k < N2; k++) w[(N2-1-k)*BW2 +: BW2] = rows[k][(N2-1-c)*BW2 +: BW2];
    return w;
  endfunction

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         m;
    logic         r;
    logic         exp_rdy;
    logic         exp_v;
    logic [W-1:0] exp_d;
    logic         exp_m;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic v, input logic [W-1:0] d, input logic m, input logic r,
                         input logic erdy, input logic ev, input logic [W-1:0] ed, input logic em);
    vec_t x;
    x.v = v; x.d = d; x.m = m; x.r = r;
    x.exp_rdy = erdy; x.exp_v = ev; x.exp_d = ed; x.exp_m = em;
    vecs.push_back(x);
  endtask

  initial begin
    int in_cnt, out_cnt, blk, idx;
    logic [W-1:0] exp_d;
    logic [3:0][W2-1:0] stage;
    logic smode;
    int srow, nin, cyc;
    logic [W2-1:0] q[$];
    logic qm[$];
    logic exp_rdy4;

    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_mode = 1'b0; i_ready = 1'b0;
    c_valid = 1'b0; c_data = '0; c_mode = 1'b0; c_ready = 1'b0;

    // Transpose block 0 into bank 0, then drain
    for (int r = 0; r < N; r++) add_vec(1, row_w(0, r), 1, 1, 1, 0, '0, 0);
    for (int c = 0; c < N; c++) add_vec(0, '0, 0, 1, 1, 1, col_w(0, c), 1);
    add_vec(0, '0, 0, 1, 1, 0, '0, 0);
    // Pass-through block 1 into bank 1, one held beat at index 3
    for (int r = 0; r < N; r++) add_vec(1, row_w(1, r), 0, 1, 1, 0, '0, 0);
    for (int c = 0; c < N; c++) begin
      if (c == 3) add_vec(0, '0, 0, 0, 1, 1, row_w(1, c), 0);
      add_vec(0, '0, 0, 1, 1, 1, row_w(1, c), 0);
    end
    add_vec(0, '0, 0, 1, 1, 0, '0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", o_valid, 0);
    check("reset_ready", o_ready, 1);
    check("reset_data", o_data, '0);
    check("reset_mode", o_mode, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      i_valid = vecs[i].v; i_data = vecs[i].d; i_mode = vecs[i].m; i_ready = vecs[i].r;
      check($sformatf("vec%0d_ready", i), o_ready, vecs[i].exp_rdy);
      check($sformatf("vec%0d_valid", i), o_valid, vecs[i].exp_v);
      check($sformatf("vec%0d_data", i), o_data, vecs[i].exp_d);
      check($sformatf("vec%0d_mode", i), o_mode, vecs[i].exp_m);
      @(posedge clk); #1;
    end

    // Reset while a full block is waiting
    for (int r = 0; r < N; r++) begin
      i_valid = 1'b1; i_data = row_w(2, r); i_mode = 1'b1; i_ready = 1'b0;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    check("pre_reset_valid", o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", o_valid, 0);
    check("async_reset_ready", o_ready, 1);
    check("async_reset_data", o_data, '0);
    check("async_reset_mode", o_mode, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Partial block then reset: those rows must be discarded
    for (int r = 0; r < 3; r++) begin
      i_valid = 1'b1; i_data = row_w(5, r); i_mode = 1'b1;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int r = 0; r < N; r++) begin
      i_valid = 1'b1; i_data = row_w(3, r); i_mode = 1'b0; i_ready = 1'b1;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    for (int c = 0; c < N; c++) begin
      check("post_reset_valid", o_valid, 1);
      check("post_reset_data", o_data, row_w(3, c));
      check("post_reset_mode", o_mode, 0);
      @(posedge clk); #1;
    end
    check("post_reset_idle", o_valid, 0);

    // Streaming: 4 back-to-back blocks, modes 1,0,1,0
    in_cnt = 0; out_cnt = 0;
    for (int cy = 0; cy < 45; cy++) begin
      i_ready = 1'b1;
      if (in_cnt < 32) begin
        i_valid = 1'b1;
        i_data  = row_w(4 + in_cnt / 8, in_cnt % 8);
        i_mode  = ((in_cnt / 8) % 2) == 0;
      end else begin
        i_valid = 1'b0;
      end
      if (in_cnt < 32) check("stream_ready", o_ready, 1);
      if (cy >= 8 && cy < 40) check("stream_bubble", o_valid, 1);
      if (o_valid) begin
        blk = out_cnt / 8; idx = out_cnt % 8;
        exp_d = (blk % 2 == 0) ? col_w(4 + blk, idx) : row_w(4 + blk, idx);
        check($sformatf("stream_data%0d", out_cnt), o_data, exp_d);
        check("stream_mode", o_mode, (blk % 2) == 0);
        out_cnt++;
      end
      if (i_valid && in_cnt < 32) in_cnt++;
      @(posedge clk); #1;
    end
    check("stream_out_count", 80'(out_cnt), 80'(32));

    // Backpressure: 20 rows offered with i_ready=0
    for (int k = 0; k < 20; k++) begin
      i_valid = 1'b1; i_ready = 1'b0;
      if (k < 16) begin
        i_data = row_w(8 + k / 8, k % 8); i_mode = (k < 8);
      end else begin
        i_data = '1; i_mode = 1'b1;
      end
      check($sformatf("bp_ready%0d", k), o_ready, k < 16);
      check($sformatf("bp_valid%0d", k), o_valid, k >= 8);
      @(posedge clk); #1;
    end
    check("bp_ready_held", o_ready, 0);
    for (int k = 0; k < 16; k++) begin
      i_valid = (k < 8); i_data = '1; i_mode = 1'b1; i_ready = 1'b1;
      check($sformatf("drain_ready%0d", k), o_ready, k >= 8);
      check($sformatf("drain_valid%0d", k), o_valid, 1);
      check($sformatf("drain_data%0d", k), o_data, (k < 8) ? col_w(8, k) : row_w(9, k - 8));
      check($sformatf("drain_mode%0d", k), o_mode, k < 8);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    check("drain_empty", o_valid, 0);

    // Random valid/ready gaps on the N=4, BW=3 instance
    srow = 0; nin = 0; cyc = 0; smode = 1'b0; stage = '0;
    while ((nin < 1000 || q.size() > 0) && cyc < 20000) begin
      c_valid = (nin < 1000) && ($urandom_range(0, 9) < 7);
      c_data  = W2'($urandom);
      c_mode  = 1'($urandom);
      c_ready = ($urandom_range(0, 9) < 7);
      exp_rdy4 = (q.size() <= 4);
      check("rand_valid", c_ovalid, q.size() > 0);
      check("rand_ready", c_oready, exp_rdy4);
      check("rand_data", c_odata, (q.size() > 0) ? q[0] : '0);
      check("rand_mode", c_omode, (q.size() > 0) ? qm[0] : 1'b0);
      if (q.size() > 0 && c_ready) begin
        void'(q.pop_front());
        void'(qm.pop_front());
      end
      if (c_valid && exp_rdy4) begin
        stage[srow] = c_data;
        if (srow == 0) smode = c_mode;
        nin++;
        if (srow == 3) begin
          for (int c = 0; c < N2; c++) begin
            q.push_back(smode ? tr4(stage, c) : stage[c]);
            qm.push_back(smode);
          end
          srow = 0;
        end else begin
          srow++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    c_valid = 1'b0;
    check("rand_in_count", 80'(nin), 80'(1000));
    check("rand_queue_empty", 80'(q.size()), 80'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tp_mem_pingpong.md
# tp_mem_pingpong

Parametrised N×N block transpose memory with two ping-pong banks and valid/ready handshakes on both sides. Each bank collects N input rows and then emits N output words, so one bank fills while the other drains. In steady state one word per cycle is sustained on each side. Per-block mode selects transposed (column) or pass-through (row) readout. The block sits between a row-wise transform stage and a column-wise transform stage.

## Interface
- BW, 10, bits per element (≥1)
- N, 8, elements per word and rows per block; power of two, 2..32
- i_clk  in  1  clock, rising edge
- i_Reset  in  1  asynchronous, active-low reset
- i_data  in  N*BW  input row; element j occupies bits [(N-j)*BW-1 : (N-j-1)*BW], so element 0 is the MSB slice
- i_valid  in  1  input word valid
- o_ready  out  1  block can accept i_data this cycle
- i_mode  in  1  1 = transpose, 0 = pass-through; sampled with the first row of each block
- o_data  out  N*BW  output word, same element packing as i_data
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts o_data
- o_mode  out  1  mode of the block currently being output

## Operation
- Storage: bank[b][r] for b in {0,1} and r in 0..N-1, each N*BW bits.
- Each bank has a full flag and a stored mode bit.
- Write side:
  - Pointers are wbank (1 bit) and wrow (log2 N bits).
  - o_ready = !full[wbank].
  - Input accept = i_valid && o_ready. On accept, bank[wbank][wrow] ← i_data.
  - If wrow==0, the stored mode of wbank ← i_mode.
  - wrow increments on each accept. On accept with wrow==N-1: full[wbank] ← 1, wbank toggles, wrow wraps to 0.
- Read side:
  - Pointers are rbank and ridx.
  - o_valid = full[rbank].
  - Transpose mode: o_data element k = bank[rbank][k] element ridx, i.e. column ridx with row 0 in the MSB slice.
  - Pass-through mode: o_data = bank[rbank][ridx].
  - Output accept = o_valid && i_ready. ridx increments on each output accept. On output accept with ridx==N-1: full[rbank] ← 0, rbank toggles, ridx wraps to 0.
- While o_valid=0, o_data is forced to 0.
- o_data, o_valid and o_mode must hold stable until accepted.
- i_data is ignored when o_ready=0, and i_valid may be held high during that time.
- Mid-block idle cycles (i_valid=0 or i_ready=0) freeze the respective pointer. Partial blocks are never emitted.
- Simultaneous set and clear of the same bank's full flag cannot occur, because a bank cannot be written while full. Write-side and read-side events on different banks in the same cycle are independent.

## Timing
- Reset, asynchronous and taking effect immediately:
  - full[0..1]=0; wbank=rbank=0; wrow=ridx=0.
  - o_valid=0, o_ready=1, o_data=0, o_mode=0.
  - Bank contents are not reset.
- Latency: last row accepted at edge t → o_valid=1 with column 0 in the cycle following edge t, i.e. one clock.
- A freed bank is writable in the cycle after its last output accept. o_ready is a function of flops only, with no combinational path from i_ready.
- o_valid and o_data depend only on flops, with no path from i_valid or i_data.
- Throughput: continuous input and output at 1 word/cycle with no bubbles, given i_ready=1. With i_ready=0, at most 2N rows are accepted before o_ready drops.
- Reset asserted mid-block discards all buffered data. The first accept after release starts a new block in bank 0.

## Structure
- Shared package tp_pkg holds:
  - the default constants TP_BW=10 and TP_N=8
  - localparam IDX_W = $clog2(N)
  - function tp_elem(word, j) returning the BW-bit slice at element j
- Sub-module tp_bank (one N×N register array):
  - ports: write enable, row index, row data, read index, mode
  - its read mux produces the column or the row
- The top instantiates two tp_bank instances plus the pointer/flag control and the output mux selected by rbank.

## Test plan
- Reset and idle: assert i_Reset=0 mid-run → o_valid=0, o_ready=1, o_data=0 immediately; after release, the first block lands in bank 0.
- Single transpose block (N=8, BW=10): row r element j = 8r+j, i_mode=1, i_ready=1 → output word c has element k = 8k+c. o_valid rises one cycle after the 8th row; 8 consecutive beats; o_mode=1.
- Pass-through: same stimulus with i_mode=0 → output word r equals input row r, in order.
- Streaming: 4 back-to-back blocks alternating mode 1,0,1,0, with i_valid=i_ready=1 throughout → o_ready never drops after the first block, zero bubbles, 32 outputs correct, and o_mode follows 1,0,1,0.
- Backpressure: i_ready=0 while 20 rows are offered → exactly 16 accepted and o_ready=0 from then on. Raising i_ready drains bank 0, then bank 1. o_ready returns to 1 one cycle after the 8th drain.
- Random valid/ready gaps (N=4, BW=3, 1000 words) checked against a scoreboard model → no loss, duplication or reordering, and o_data stable while o_valid && !i_ready.
